// File: rtl/edit_controller_pkg.sv
// Shared types and constants for the front-panel edit controller.
// Key indices order the debouncer bank inside the top level.
package edit_ctrl_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    EDIT = 1'b1
  } state_t;

  localparam int unsigned NUM_SCREENS  = 4;
  localparam logic [2:0]  EDITPOS_LAST = 3'd7;

  localparam logic [1:0] SCREEN_TIME  = 2'd0;
  localparam logic [1:0] SCREEN_DATE  = 2'd1;
  localparam logic [1:0] SCREEN_ZONE  = 2'd2;
  localparam logic [1:0] SCREEN_ALARM = 2'd3;

  localparam int NUM_KEYS  = 4;
  localparam int KEY_MODE  = 0;
  localparam int KEY_NEXT  = 1;
  localparam int KEY_PLUS  = 2;
  localparam int KEY_MINUS = 3;

  function automatic logic [1:0] next_screen(input logic [1:0] s);
    return (32'(s) == NUM_SCREENS - 1) ? SCREEN_TIME : s + 2'd1;
  endfunction

endpackage

// File: rtl/edit_controller_key_debounce.sv
// One push-button: 2-FF synchroniser, stable-sample debounce, and a
// one-cycle press flag when the accepted level falls to 0.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = key_raw;
    sync2_d = sync1_q;
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    // Count consecutive samples that disagree with the accepted level.
    if (sync2_q != level_q) begin
      if (cnt_q >= CNT_LAST) begin
        level_d = sync2_q;
        press_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/edit_controller.sv
// RUN/EDIT sequencer for the clock/calendar front panel: debounced keys,
// screen and digit selection, step pulses with hold-to-repeat, timeout, blink.
module edit_controller
  import edit_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int TIMEOUT_CYCLES  = 500000000,
  parameter int BLINK_HALF      = 12500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       KeyModeRaw,
  input  logic       KeyNextRaw,
  input  logic       KeyPlusRaw,
  input  logic       KeyMinusRaw,
  output logic       EditMode,
  output logic [2:0] EditPos,
  output logic [1:0] screen,
  output logic       KeyPlus,
  output logic       KeyMinus,
  output logic       Blink
);

  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(REP_MAX + 1);
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BW = $clog2(BLINK_HALF + 1);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);
  localparam logic [IW-1:0] IDLE_LAST   = IW'(TIMEOUT_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST  = BW'(BLINK_HALF - 1);

  logic key_raw   [NUM_KEYS];
  logic key_level [NUM_KEYS];
  logic key_press [NUM_KEYS];

  assign key_raw[KEY_MODE]  = KeyModeRaw;
  assign key_raw[KEY_NEXT]  = KeyNextRaw;
  assign key_raw[KEY_PLUS]  = KeyPlusRaw;
  assign key_raw[KEY_MINUS] = KeyMinusRaw;

  generate
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
        .clk     (clk),
        .reset   (reset),
        .key_raw (key_raw[gi]),
        .level   (key_level[gi]),
        .press   (key_press[gi])
      );
    end
  endgenerate

  state_t        state_q, state_d;
  logic [1:0]    screen_q, screen_d;
  logic [2:0]    edit_pos_q, edit_pos_d;
  logic          key_plus_q, key_plus_d;
  logic          key_minus_q, key_minus_d;
  logic          blink_q, blink_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic          rep_armed_q, rep_armed_d;
  logic          rep_phase_q, rep_phase_d;
  logic          rep_fire;

  logic mode_p, next_p, plus_p, minus_p, plus_held, minus_held;
  logic in_edit, any_press, timeout_hit, one_held;
  logic step_plus, step_minus, step_ev, rep_pulse;

  assign mode_p      = key_press[KEY_MODE];
  assign next_p      = key_press[KEY_NEXT];
  assign plus_p      = key_press[KEY_PLUS];
  assign minus_p     = key_press[KEY_MINUS];
  assign plus_held   = ~key_level[KEY_PLUS];
  assign minus_held  = ~key_level[KEY_MINUS];
  assign in_edit     = (state_q == EDIT);
  assign any_press   = mode_p | next_p | plus_p | minus_p;
  assign timeout_hit = in_edit & ~any_press & (idle_q >= IDLE_LAST);
  assign one_held    = plus_held ^ minus_held;
  assign step_plus   = plus_p & ~minus_p;
  assign step_minus  = minus_p & ~plus_p;
  assign step_ev     = in_edit & ~mode_p & ~next_p & (step_plus | step_minus);
  assign rep_pulse   = rep_fire & in_edit & ~mode_p & ~next_p & ~timeout_hit;

  always_ff @(posedge clk) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:  if (!mode_p && next_p) state_d = EDIT;
      EDIT: if (mode_p || timeout_hit) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    screen_d = screen_q;
    if (!in_edit && mode_p) screen_d = next_screen(screen_q);

    edit_pos_d = edit_pos_q;
    if (!in_edit || state_d == RUN) edit_pos_d = '0;
    else if (next_p) edit_pos_d = (edit_pos_q == EDITPOS_LAST) ? 3'd0 : edit_pos_q + 3'd1;

    // Repeat arms on an accepted step press and runs only while that key alone stays held.
    rep_fire    = 1'b0;
    rep_cnt_d   = rep_cnt_q;
    rep_armed_d = rep_armed_q;
    rep_phase_d = rep_phase_q;
    if (!in_edit || !one_held) begin
      rep_cnt_d   = '0;
      rep_armed_d = 1'b0;
      rep_phase_d = 1'b0;
    end else if (step_ev) begin
      rep_cnt_d   = '0;
      rep_armed_d = 1'b1;
      rep_phase_d = 1'b0;
    end else if (rep_armed_q) begin
      if (rep_cnt_q >= (rep_phase_q ? PERIOD_LAST : DELAY_LAST)) begin
        rep_fire    = 1'b1;
        rep_cnt_d   = '0;
        rep_phase_d = 1'b1;
      end else begin
        rep_cnt_d = rep_cnt_q + 1'b1;
      end
    end

    key_plus_d  = 1'b1;
    key_minus_d = 1'b1;
    if (step_ev) begin
      key_plus_d  = ~step_plus;
      key_minus_d = ~step_minus;
    end else if (rep_pulse) begin
      key_plus_d  = ~plus_held;
      key_minus_d = ~minus_held;
    end

    idle_d = '0;
    if (in_edit && !any_press && state_d == EDIT)
      idle_d = (idle_q >= IDLE_LAST) ? idle_q : idle_q + 1'b1;

    blink_d     = blink_q;
    blink_cnt_d = blink_cnt_q;
    if (state_d == RUN || !in_edit || next_p || plus_p || minus_p || rep_pulse) begin
      blink_d     = 1'b1;
      blink_cnt_d = '0;
    end else if (blink_cnt_q >= BLINK_LAST) begin
      blink_d     = ~blink_q;
      blink_cnt_d = '0;
    end else begin
      blink_cnt_d = blink_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      screen_q    <= SCREEN_TIME;
      edit_pos_q  <= '0;
      key_plus_q  <= 1'b1;
      key_minus_q <= 1'b1;
      blink_q     <= 1'b1;
      blink_cnt_q <= '0;
      idle_q      <= '0;
      rep_cnt_q   <= '0;
      rep_armed_q <= 1'b0;
      rep_phase_q <= 1'b0;
    end else begin
      screen_q    <= screen_d;
      edit_pos_q  <= edit_pos_d;
      key_plus_q  <= key_plus_d;
      key_minus_q <= key_minus_d;
      blink_q     <= blink_d;
      blink_cnt_q <= blink_cnt_d;
      idle_q      <= idle_d;
      rep_cnt_q   <= rep_cnt_d;
      rep_armed_q <= rep_armed_d;
      rep_phase_q <= rep_phase_d;
    end
  end

  assign EditMode = (state_q == EDIT);
  assign EditPos  = edit_pos_q;
  assign screen   = screen_q;
  assign KeyPlus  = key_plus_q;
  assign KeyMinus = key_minus_q;
  assign Blink    = blink_q;

endmodule

// File: tb/tb_edit_controller.sv
// Directed bench for edit_controller with shortened timing parameters;
// expected values are hand-derived from the key-to-output latencies.
module tb_edit_controller;

  localparam int K_MODE  = 0;
  localparam int K_NEXT  = 1;
  localparam int K_PLUS  = 2;
  localparam int K_MINUS = 3;

  logic       clk;
  logic       reset;
  logic [3:0] raw_n;
  logic       EditMode;
  logic [2:0] EditPos;
  logic [1:0] screen;
  logic       KeyPlus;
  logic       KeyMinus;
  logic       Blink;

  int checks;
  int failures;

  edit_controller #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (20),
    .REPEAT_PERIOD   (5),
    .TIMEOUT_CYCLES  (100),
    .BLINK_HALF      (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .KeyModeRaw  (raw_n[K_MODE]),
    .KeyNextRaw  (raw_n[K_NEXT]),
    .KeyPlusRaw  (raw_n[K_PLUS]),
    .KeyMinusRaw (raw_n[K_MINUS]),
    .EditMode    (EditMode),
    .EditPos     (EditPos),
    .screen      (screen),
    .KeyPlus     (KeyPlus),
    .KeyMinus    (KeyMinus),
    .Blink       (Blink)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("check %s ok (%0d)", tag, got);
    end
  endtask

  // Press lands on the 7th clock edge after the raw edge; the tap lasts 18 cycles.
  task automatic tap(input int idx);
    raw_n[idx] = 1'b0;
    repeat (10) @(negedge clk);
    raw_n[idx] = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_editmode"}, 32'(EditMode), 0);
    check({pfx, "_editpos"},  32'(EditPos),  0);
    check({pfx, "_screen"},   32'(screen),   0);
    check({pfx, "_keyplus"},  32'(KeyPlus),  1);
    check({pfx, "_keyminus"}, 32'(KeyMinus), 1);
    check({pfx, "_blink"},    32'(Blink),    1);
  endtask

  initial begin
    int exp_rep [9];
    int plus_hits [$];
    int minus_lows;
    int lows;

    exp_rep = '{7, 27, 32, 37, 42, 47, 52, 57, 62};
    checks = 0;
    failures = 0;
    reset = 1'b1;
    raw_n = 4'hF;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");

    // Three-cycle glitch must be rejected.
    raw_n[K_MODE] = 1'b0;
    repeat (3) @(negedge clk);
    raw_n[K_MODE] = 1'b1;
    repeat (12) @(negedge clk);
    check("glitch_screen", 32'(screen), 0);

    // Held press: screen steps exactly 7 edges after the raw falling edge.
    raw_n[K_MODE] = 1'b0;
    repeat (6) @(negedge clk);
    check("mode_lat6_screen", 32'(screen), 0);
    @(negedge clk);
    check("mode_lat7_screen", 32'(screen), 1);
    repeat (3) @(negedge clk);
    raw_n[K_MODE] = 1'b1;
    repeat (8) @(negedge clk);
    tap(K_MODE);
    check("mode_screen2", 32'(screen), 2);
    tap(K_MODE);
    check("mode_screen3", 32'(screen), 3);
    tap(K_MODE);
    check("mode_wrap_screen0", 32'(screen), 0);

    // Edit navigation.
    tap(K_NEXT);
    check("enter_editmode", 32'(EditMode), 1);
    check("enter_editpos", 32'(EditPos), 0);
    for (int i = 1; i <= 8; i++) begin
      tap(K_NEXT);
      check($sformatf("next_pos%0d", i), 32'(EditPos), 32'(i % 8));
    end
    tap(K_MODE);
    check("exit_editmode", 32'(EditMode), 0);
    check("exit_editpos", 32'(EditPos), 0);
    check("exit_screen", 32'(screen), 0);

    // Auto-repeat: press at edge 7, repeats at 27 then every 5, release at 60.
    tap(K_NEXT);
    check("rep_editmode", 32'(EditMode), 1);
    minus_lows = 0;
    raw_n[K_PLUS] = 1'b0;
    for (int k = 1; k <= 75; k++) begin
      @(negedge clk);
      if (KeyPlus == 1'b0) plus_hits.push_back(k);
      if (KeyMinus == 1'b0) minus_lows++;
      if (k == 60) raw_n[K_PLUS] = 1'b1;
    end
    check("rep_pulse_count", 32'(plus_hits.size()), 9);
    for (int i = 0; i < 9 && i < plus_hits.size(); i++)
      check($sformatf("rep_pulse%0d_cycle", i), 32'(plus_hits[i]), 32'(exp_rep[i]));
    check("rep_minus_lows", 32'(minus_lows), 0);

    // Mode and Plus accepted in the same cycle: exit wins, no step pulse.
    lows = 0;
    raw_n[K_MODE] = 1'b0;
    raw_n[K_PLUS] = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (KeyPlus == 1'b0) lows++;
      if (k == 10) begin
        raw_n[K_MODE] = 1'b1;
        raw_n[K_PLUS] = 1'b1;
      end
    end
    check("prio_plus_lows", 32'(lows), 0);
    check("prio_editmode", 32'(EditMode), 0);
    check("prio_screen", 32'(screen), 0);

    // Plus and Minus together: no pulse on either output.
    tap(K_NEXT);
    lows = 0;
    raw_n[K_PLUS] = 1'b0;
    raw_n[K_MINUS] = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (KeyPlus == 1'b0 || KeyMinus == 1'b0) lows++;
      if (k == 20) begin
        raw_n[K_PLUS] = 1'b1;
        raw_n[K_MINUS] = 1'b1;
      end
    end
    check("both_step_lows", 32'(lows), 0);
    check("both_editmode", 32'(EditMode), 1);
    tap(K_MODE);
    check("both_exit_editmode", 32'(EditMode), 0);

    // Timeout with blink phase; j counts edges since EDIT entry.
    raw_n[K_NEXT] = 1'b0;
    repeat (7) @(negedge clk);
    check("to_enter_editmode", 32'(EditMode), 1);
    check("to_enter_blink", 32'(Blink), 1);
    for (int j = 1; j <= 100; j++) begin
      @(negedge clk);
      if (j == 3) raw_n[K_NEXT] = 1'b1;
      if (j == 7)  check("blink_j7", 32'(Blink), 1);
      if (j == 8)  check("blink_j8", 32'(Blink), 0);
      if (j == 16) check("blink_j16", 32'(Blink), 1);
      if (j == 24) check("blink_j24", 32'(Blink), 0);
      if (j == 99) check("to_j99_editmode", 32'(EditMode), 1);
      if (j == 100) begin
        check("to_j100_editmode", 32'(EditMode), 0);
        check("to_j100_blink", 32'(Blink), 1);
        check("to_j100_editpos", 32'(EditPos), 0);
      end
    end

    // Plus press landing at j=90 restarts the idle count.
    raw_n[K_NEXT] = 1'b0;
    repeat (7) @(negedge clk);
    check("to2_enter_editmode", 32'(EditMode), 1);
    for (int j = 1; j <= 190; j++) begin
      @(negedge clk);
      if (j == 3)  raw_n[K_NEXT] = 1'b1;
      if (j == 83) raw_n[K_PLUS] = 1'b0;
      if (j == 88) raw_n[K_PLUS] = 1'b1;
      if (j == 90) begin
        check("to2_j90_keyplus", 32'(KeyPlus), 0);
        check("to2_j90_blink", 32'(Blink), 1);
      end
      if (j == 100) check("to2_j100_editmode", 32'(EditMode), 1);
      if (j == 189) check("to2_j189_editmode", 32'(EditMode), 1);
      if (j == 190) check("to2_j190_editmode", 32'(EditMode), 0);
    end

    // Reset in the middle of auto-repeat with screen 2 and EditPos 1.
    tap(K_MODE);
    tap(K_MODE);
    check("pre_reset_screen", 32'(screen), 2);
    tap(K_NEXT);
    tap(K_NEXT);
    check("pre_reset_editpos", 32'(EditPos), 1);
    raw_n[K_PLUS] = 1'b0;
    repeat (30) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    reset = 1'b0;
    lows = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (KeyPlus == 1'b0) lows++;
    end
    check("post_reset_plus_lows", 32'(lows), 0);
    check("post_reset_editmode", 32'(EditMode), 0);
    raw_n[K_PLUS] = 1'b1;
    repeat (10) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/edit_controller.md
# edit_controller

Front-panel sequencer for the clock/calendar. It debounces the four raw push-buttons and runs the RUN/EDIT mode state machine. It drives the shared `EditMode`, `EditPos`, `screen`, `KeyPlus` and `KeyMinus` signals that every field counter (seconds through years) decodes. It sits between the board keys and the counter bank, and owns hold-to-repeat, the edit timeout and the digit-blink phase.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable samples needed to accept a new key level.
- `REPEAT_DELAY`, default 25000000: hold time before auto-repeat starts.
- `REPEAT_PERIOD`, default 5000000: spacing of auto-repeat pulses.
- `TIMEOUT_CYCLES`, default 500000000: idle time in EDIT before forced exit.
- `BLINK_HALF`, default 12500000: half-period of `Blink`.

Ports:
- `clk`  in  1  main clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `KeyModeRaw`, `KeyNextRaw`, `KeyPlusRaw`, `KeyMinusRaw`  in  1 each  raw buttons, active-low, asynchronous to `clk`.
- `EditMode`  out  1  high while in EDIT.
- `EditPos`  out  3  edit digit; 0 = leftmost, 7 = rightmost.
- `screen`  out  2  current screen, 0..3.
- `KeyPlus`, `KeyMinus`  out  1 each  active-low, one-cycle step pulses; idle high.
- `Blink`  out  1  digit-visible phase for the display.

## Operation

- **Key conditioning**
  - Each raw key passes through a 2-FF synchroniser, then a debounce counter.
  - The debounced level changes only after `DEBOUNCE_CYCLES` consecutive samples of the new value.
  - A press event is the debounced level going 1→0.
- **States:** `RUN`, `EDIT`.
- **RUN**
  - Mode press: `screen` ← (`screen`+1) mod 4.
  - Next press: go to EDIT with `EditPos` ← 0.
  - Plus and Minus presses are ignored; `KeyPlus` and `KeyMinus` stay high.
- **EDIT**
  - Mode press: go to RUN with `EditPos` ← 0.
  - Next press: `EditPos` ← (`EditPos`+1) mod 8.
  - Plus press: `KeyPlus` low for exactly 1 cycle. Minus press: `KeyMinus` low for exactly 1 cycle.
  - `screen` is frozen.
- **Auto-repeat**
  - Applies while exactly one of Plus/Minus stays debounced-low in EDIT.
  - First repeat pulse comes `REPEAT_DELAY` cycles after the press pulse, then one every `REPEAT_PERIOD` cycles.
  - Releasing the key, or pressing the other one, stops repeat and clears the repeat counter.
- **Simultaneous events in one cycle:** Mode > Next > Plus/Minus. Only the highest-priority event acts; the others are discarded, not queued. Plus and Minus together produce no pulse.
- **Timeout**
  - The idle counter clears on any press event and on entry to EDIT.
  - When it reaches `TIMEOUT_CYCLES` in EDIT: go to RUN, `EditPos` ← 0.
- **Blink**
  - Forced to 1 in RUN.
  - In EDIT it toggles every `BLINK_HALF` cycles.
  - It restarts high, with the counter cleared, on entering EDIT and on any Next/Plus/Minus press or repeat pulse, so the edited digit is visible right after a change.
- **Reset values**
  - `EditMode` 0, `EditPos` 0, `screen` 0, `KeyPlus` 1, `KeyMinus` 1, `Blink` 1.
  - State is RUN; debounced levels are 1; all counters are 0.
  - A key held through reset produces a press once debounce completes after reset release.

## Timing

- All outputs are registered.
- A debounced press in cycle N updates the outputs at the clock edge ending cycle N, so they are visible in N+1.
- Raw-to-output latency: 2 (sync) + `DEBOUNCE_CYCLES` + 1 cycles.
- `KeyPlus`/`KeyMinus` pulses are exactly 1 cycle wide. At most one pulse per cycle, and never both outputs low in the same cycle.
- `reset` asserted mid-pulse, mid-repeat or mid-debounce returns every output to its reset value on the next edge.
- Counter widths are sized with `$clog2` of the corresponding parameter. Counters saturate and never wrap.

## Structure

- Package `edit_ctrl_pkg` holds:
  - the state enum {`RUN`, `EDIT`};
  - `NUM_SCREENS` = 4;
  - `EDITPOS_LAST` = 7;
  - `SCREEN_TIME` = 0, `SCREEN_DATE` = 1, `SCREEN_ZONE` = 2, `SCREEN_ALARM` = 3.
- Sub-module `key_debounce` (synchroniser, debounce counter, press-edge output), parameterised by `DEBOUNCE_CYCLES`, instantiated 4×.
- The FSM, repeat timer, idle timer and blink timer live in the top level.

## Test plan

Benches override the parameters to `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=20, `REPEAT_PERIOD`=5, `TIMEOUT_CYCLES`=100, `BLINK_HALF`=8.

- **Debounce:** `KeyModeRaw` glitches low for 3 cycles → `screen` stays 0. Held low for 10 cycles → `screen`=1, 7 cycles after the falling edge. Four presses → `screen` wraps back to 0.
- **Edit navigation:** Next press → `EditMode`=1, `EditPos`=0. Eight more Next presses → `EditPos` goes 1..7 then 0. Mode press → `EditMode`=0, `EditPos`=0, `screen` unchanged.
- **Auto-repeat:** in EDIT, hold `KeyPlusRaw` low for 60 cycles after debounce → `KeyPlus` low 1 cycle at the press, then at +20, +25, +30 … (9 pulses total). `KeyMinus` stays high throughout.
- **Priority / simultaneous:** Mode and Plus debounce in the same cycle in EDIT → exit to RUN, no `KeyPlus` pulse. Plus and Minus together → no pulse on either.
- **Timeout and blink:** enter EDIT, no keys → `Blink` toggles every 8 cycles, exit to RUN at cycle 100 with `Blink`=1. A Plus press at cycle 90 restarts the idle count, so exit happens 100 cycles after that press.
- **Reset mid-operation:** assert `reset` during auto-repeat in EDIT with `screen`=2 → next edge gives `EditMode`=0, `EditPos`=0, `screen`=0, `KeyPlus`=1, `Blink`=1, and no further pulses.
